// File: rtl/enm_bullet_pool.sv
// enm_bullet_pool: 3*N_ENM enemy bullet slots (| / \ per enemy) with player hit detection.
// Define ENM_BULLET_IFRAME_EN to add a post-hit invulnerability window of IFRAME ticks.
module enm_bullet_pool #(
    parameter int unsigned N_ENM  = 4,
    parameter int unsigned W      = 10,
    parameter int unsigned SPD_V  = 10,
    parameter int unsigned SPD_D  = 7,
    parameter int unsigned XMIN   = 8,
    parameter int unsigned XMAX   = 432,
    parameter int unsigned YMIN   = 8,
    parameter int unsigned YMAX   = 472,
    parameter int unsigned HIT_XL = 10,
    parameter int unsigned HIT_XR = 12,
    parameter int unsigned HIT_Y  = 11,
    parameter int unsigned RELOAD = 8,
    parameter int unsigned IFRAME = 16
) (
    input  logic                   clk22,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic [W-1:0]           reimux,
    input  logic [W-1:0]           reimuy,
    input  logic [N_ENM*W-1:0]     enm_x,
    input  logic [N_ENM*W-1:0]     enm_y,
    input  logic [N_ENM-1:0]       enm_alive,
    output logic [3*N_ENM*W-1:0]   bullet_x,
    output logic [3*N_ENM*W-1:0]   bullet_y,
    output logic [3*N_ENM-1:0]     bullet_vld,
    output logic                   shot,
    output logic [7:0]             hit_cnt
);
    localparam int unsigned NS = 3 * N_ENM;
    localparam int unsigned SW = W + 2;
    localparam int unsigned RW = (RELOAD > 1) ? $clog2(RELOAD) : 1;

    localparam logic signed [SW-1:0] X_LO = SW'(XMIN);
    localparam logic signed [SW-1:0] X_HI = SW'(XMAX);
    localparam logic signed [SW-1:0] Y_LO = SW'(YMIN);
    localparam logic signed [SW-1:0] Y_HI = SW'(YMAX);
    localparam logic signed [SW-1:0] S_V  = SW'(SPD_V);
    localparam logic signed [SW-1:0] S_D  = SW'(SPD_D);
    localparam logic signed [SW-1:0] H_XL = SW'(HIT_XL);
    localparam logic signed [SW-1:0] H_XR = SW'(HIT_XR);
    localparam logic signed [SW-1:0] H_Y  = SW'(HIT_Y);
    localparam logic [RW-1:0]        RL_LAST = RW'(RELOAD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FLY, ST_COOL} slot_st_t;

    slot_st_t             st_q [NS];
    slot_st_t             st_d [NS];
    logic [W-1:0]         px_q [NS];
    logic [W-1:0]         px_d [NS];
    logic [W-1:0]         py_q [NS];
    logic [W-1:0]         py_d [NS];
    logic [RW-1:0]        rl_q [NS];
    logic [RW-1:0]        rl_d [NS];
    logic [NS-1:0]        vld_q, vld_d;

    logic [W-1:0]         sx_c [NS];
    logic [W-1:0]         sy_c [NS];
    logic [W-1:0]         mx_c [NS];
    logic [W-1:0]         my_c [NS];
    logic [NS-1:0]        alive_c, hit_c, out_c;
    logic signed [SW-1:0] hx_lo_c, hx_hi_c, hy_lo_c, hy_hi_c;
    logic                 mask_c, hit_any_c;

    // Hitbox bounds in W+2 signed bits so values near 0 or 2^W-1 never wrap
    assign hx_lo_c = $signed({2'b00, reimux}) - H_XL;
    assign hx_hi_c = $signed({2'b00, reimux}) + H_XR;
    assign hy_lo_c = $signed({2'b00, reimuy}) - H_Y;
    assign hy_hi_c = $signed({2'b00, reimuy}) + H_Y;

    for (genvar k = 0; k < NS; k++) begin : g_slot
        localparam int unsigned E = k % N_ENM;
        localparam int unsigned D = k / N_ENM;
        logic signed [SW-1:0] cx, cy, nx, ny;

        assign cx = $signed({2'b00, px_q[k]});
        assign cy = $signed({2'b00, py_q[k]});
        if (D == 0) begin : g_vert
            assign nx = cx;
            assign ny = cy + S_V;
        end else if (D == 1) begin : g_left
            assign nx = cx - S_D;
            assign ny = cy + S_D;
        end else begin : g_right
            assign nx = cx + S_D;
            assign ny = cy + S_D;
        end

        assign alive_c[k] = enm_alive[E];
        assign sx_c[k]    = enm_x[E*W +: W];
        assign sy_c[k]    = enm_y[E*W +: W];
        assign mx_c[k]    = nx[W-1:0];
        assign my_c[k]    = ny[W-1:0];
        assign hit_c[k]   = (st_q[k] == ST_FLY) && (cx > hx_lo_c) && (cx < hx_hi_c)
                         && (cy > hy_lo_c) && (cy < hy_hi_c);
        assign out_c[k]   = (nx < X_LO) || (nx > X_HI) || (ny < Y_LO) || (ny > Y_HI);

        assign bullet_x[k*W +: W] = px_q[k];
        assign bullet_y[k*W +: W] = py_q[k];
    end

    assign bullet_vld = vld_q;
    assign hit_any_c  = tick && !mask_c && (|hit_c);

`ifdef ENM_BULLET_IFRAME_EN
    localparam int unsigned IW = $clog2(IFRAME + 1);
    logic [IW-1:0] ifr_q;

    // Window reloads on every hit tick and drains one step per tick
    assign mask_c = (ifr_q != '0);
    always_ff @(posedge clk22) begin
        if (!rst_n) begin
            ifr_q <= '0;
        end else if (tick) begin
            if (hit_any_c)   ifr_q <= IW'(IFRAME);
            else if (mask_c) ifr_q <= ifr_q - IW'(1);
        end
    end
`else
    // IFRAME has no effect without the window
    assign mask_c = 1'b0 && (IFRAME != 0);
`endif

    // Per-slot next state; hit and exit both land in COOL with cleared position
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            st_d[k]  = st_q[k];
            px_d[k]  = px_q[k];
            py_d[k]  = py_q[k];
            rl_d[k]  = rl_q[k];
            vld_d[k] = vld_q[k];
            if (tick) begin
                case (st_q[k])
                    ST_IDLE: begin
                        if (alive_c[k]) begin
                            st_d[k]  = ST_FLY;
                            px_d[k]  = sx_c[k];
                            py_d[k]  = sy_c[k];
                            vld_d[k] = 1'b1;
                        end
                    end
                    ST_FLY: begin
                        if ((hit_c[k] && !mask_c) || out_c[k]) begin
                            st_d[k]  = ST_COOL;
                            px_d[k]  = '0;
                            py_d[k]  = '0;
                            rl_d[k]  = '0;
                            vld_d[k] = 1'b0;
                        end else begin
                            px_d[k] = mx_c[k];
                            py_d[k] = my_c[k];
                        end
                    end
                    ST_COOL: begin
                        if (rl_q[k] == RL_LAST) begin
                            st_d[k] = ST_IDLE;
                            rl_d[k] = '0;
                        end else begin
                            rl_d[k] = rl_q[k] + RW'(1);
                        end
                    end
                    default: st_d[k] = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk22) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) begin
                st_q[k] <= ST_IDLE;
                px_q[k] <= '0;
                py_q[k] <= '0;
                rl_q[k] <= '0;
            end
            vld_q   <= '0;
            shot    <= 1'b0;
            hit_cnt <= 8'd0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                st_q[k] <= st_d[k];
                px_q[k] <= px_d[k];
                py_q[k] <= py_d[k];
                rl_q[k] <= rl_d[k];
            end
            vld_q <= vld_d;
            shot  <= hit_any_c;
            if (hit_any_c && (hit_cnt != 8'hFF)) hit_cnt <= hit_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_enm_bullet_pool.sv
// Bench for enm_bullet_pool: directed scenarios plus random play against a behavioural slot model.
// Honours ENM_BULLET_IFRAME_EN the same way the design does.
module tb_enm_bullet_pool;
    localparam int NE = 4;
    localparam int W  = 10;
    localparam int NS = 3 * NE;
    localparam int RELOAD = 8;

    logic              clk22 = 1'b0;
    logic              rst_n, tick;
    logic [W-1:0]      reimux, reimuy;
    logic [NE*W-1:0]   enm_x, enm_y;
    logic [NE-1:0]     enm_alive;
    logic [NS*W-1:0]   bullet_x, bullet_y;
    logic [NS-1:0]     bullet_vld;
    logic              shot;
    logic [7:0]        hit_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk22 = ~clk22;

    enm_bullet_pool #(.N_ENM(NE), .W(W)) dut (
        .clk22(clk22), .rst_n(rst_n), .tick(tick),
        .reimux(reimux), .reimuy(reimuy),
        .enm_x(enm_x), .enm_y(enm_y), .enm_alive(enm_alive),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_vld(bullet_vld),
        .shot(shot), .hit_cnt(hit_cnt)
    );

    // Reference model: mode 0 waiting, 1 flying, 2 reloading
    int m_mode [NS];
    int m_x [NS];
    int m_y [NS];
    int m_wait [NS];
    int m_cnt, m_ifr;
    bit m_shot, m_live = 1'b0;
    int e_i, d_i, nx, ny;
    bit any_hit, masked, is_hit;

    function automatic bit outside(input int x, input int y);
        return (x < 8) || (x > 432) || (y < 8) || (y > 472);
    endfunction

    always @(posedge clk22) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) begin
                m_mode[k] = 0; m_x[k] = 0; m_y[k] = 0; m_wait[k] = 0;
            end
            m_cnt = 0; m_ifr = 0; m_shot = 1'b0; m_live = 1'b1;
        end else if (tick) begin
            any_hit = 1'b0;
            masked  = (m_ifr > 0);
            for (int k = 0; k < NS; k++) begin
                e_i = k % NE;
                d_i = k / NE;
                if (m_mode[k] == 0) begin
                    if (enm_alive[e_i]) begin
                        m_mode[k] = 1;
                        m_x[k] = int'(enm_x[e_i*W +: W]);
                        m_y[k] = int'(enm_y[e_i*W +: W]);
                    end
                end else if (m_mode[k] == 1) begin
                    is_hit = !masked
                        && (m_x[k] > int'(reimux) - 10) && (m_x[k] < int'(reimux) + 12)
                        && (m_y[k] > int'(reimuy) - 11) && (m_y[k] < int'(reimuy) + 11);
                    nx = m_x[k] + ((d_i == 0) ? 0 : (d_i == 1) ? -7 : 7);
                    ny = m_y[k] + ((d_i == 0) ? 10 : 7);
                    if (is_hit) any_hit = 1'b1;
                    if (is_hit || outside(nx, ny)) begin
                        m_mode[k] = 2; m_x[k] = 0; m_y[k] = 0; m_wait[k] = RELOAD;
                    end else begin
                        m_x[k] = nx; m_y[k] = ny;
                    end
                end else begin
                    m_wait[k] = m_wait[k] - 1;
                    if (m_wait[k] == 0) m_mode[k] = 0;
                end
            end
            m_shot = any_hit;
            if (any_hit && m_cnt < 255) m_cnt = m_cnt + 1;
`ifdef ENM_BULLET_IFRAME_EN
            if (any_hit) m_ifr = 16;
            else if (m_ifr > 0) m_ifr = m_ifr - 1;
`endif
        end else begin
            m_shot = 1'b0;
        end
    end

    logic [NS*W-1:0] ex, ey;
    logic [NS-1:0]   ev;

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk22) begin
        if (m_live) begin
            for (int k = 0; k < NS; k++) begin
                ev[k] = (m_mode[k] == 1);
                ex[k*W +: W] = W'(m_x[k]);
                ey[k*W +: W] = W'(m_y[k]);
            end
            total = total + 5;
            if (bullet_vld !== ev) begin
                bad++; $display("FAIL cyc_vld t=%0t got=%h exp=%h", $time, bullet_vld, ev);
            end
            if (bullet_x !== ex) begin
                bad++; $display("FAIL cyc_x t=%0t got=%h exp=%h", $time, bullet_x, ex);
            end
            if (bullet_y !== ey) begin
                bad++; $display("FAIL cyc_y t=%0t got=%h exp=%h", $time, bullet_y, ey);
            end
            if (shot !== m_shot) begin
                bad++; $display("FAIL cyc_shot t=%0t got=%b exp=%b", $time, shot, m_shot);
            end
            if (hit_cnt !== 8'(m_cnt)) begin
                bad++; $display("FAIL cyc_cnt t=%0t got=%0d exp=%0d", $time, hit_cnt, m_cnt);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk22);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_enm(input int e, input int x, input int y);
        enm_x[e*W +: W] = W'(x);
        enm_y[e*W +: W] = W'(y);
    endtask

    task automatic do_reset();
        enm_alive = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    function automatic int bx(input int k);
        return int'(bullet_x[k*W +: W]);
    endfunction

    function automatic int by(input int k);
        return int'(bullet_y[k*W +: W]);
    endfunction

    initial begin
        int pulses, pe, px, py;
        rst_n = 1'b0; tick = 1'b1; reimux = '0; reimuy = '0;
        enm_x = '0; enm_y = '0; enm_alive = '0;

        // Reset with tick high, then idle ticks with no enemies
        step(2);
        rst_n = 1'b1;
        step(20);
        chk("t1_vld", int'(bullet_vld), 0);
        chk("t1_xy_nonzero", int'((|bullet_x) | (|bullet_y)), 0);
        chk("t1_shot", int'(shot), 0);
        chk("t1_cnt", int'(hit_cnt), 0);

        // Free flight, exits and respawn
        reimux = 10'd300; reimuy = 10'd400;
        set_enm(0, 100, 50);
        enm_alive = 4'b0001;
        step(1);
        chk("t2_spawn_x", bx(0), 100);
        chk("t2_spawn_y", by(0), 50);
        chk("t2_spawn_vld", int'(bullet_vld[0]), 1);
        step(13);
        chk("t2_y0_m13", by(0), 180);
        chk("t2_x4_m13", bx(4), 9);
        chk("t2_vld4_m13", int'(bullet_vld[4]), 1);
        step(1);
        chk("t2_vld4_exit", int'(bullet_vld[4]), 0);
        step(28);
        chk("t2_y0_last", by(0), 470);
        step(1);
        chk("t2_vld0_exit", int'(bullet_vld[0]), 0);
        step(9);
        chk("t2_respawn_vld", int'(bullet_vld[0]), 1);
        chk("t2_respawn_y", by(0), 50);

        // Vertical bullet walks into the player
        do_reset();
        reimux = 10'd100; reimuy = 10'd120;
        set_enm(0, 100, 50);
        enm_alive = 4'b0001;
        step(7);
        chk("t3_y0_pre", by(0), 110);
        chk("t3_shot_pre", int'(shot), 0);
        step(1);
        chk("t3_shot", int'(shot), 1);
        chk("t3_cnt", int'(hit_cnt), 1);
        chk("t3_vld0", int'(bullet_vld[0]), 0);
        step(1);
        chk("t3_shot_one", int'(shot), 0);
        chk("t3_cnt_hold", int'(hit_cnt), 1);

        // No wraparound near the coordinate limits
        do_reset();
        reimux = 10'd3; reimuy = 10'd100;
        set_enm(0, 1020, 100);
        enm_alive = 4'b0001;
        step(1);
        chk("t4_far_x", bx(0), 1020);
        step(1);
        chk("t4_far_shot", int'(shot), 0);
        chk("t4_far_vld", int'(bullet_vld[0]), 0);
        do_reset();
        reimux = 10'd3; reimuy = 10'd100;
        set_enm(0, 2, 100);
        enm_alive = 4'b0001;
        step(2);
        chk("t4_near_shot", int'(shot), 1);
        chk("t4_near_cnt", int'(hit_cnt), 1);

        // Twelve simultaneous hits, then drive the counter into saturation
        do_reset();
        reimux = 10'd100; reimuy = 10'd50;
        for (int e = 0; e < NE; e++) set_enm(e, 100, 50);
        enm_alive = 4'hF;
        step(2);
        chk("t5_multi_shot", int'(shot), 1);
        chk("t5_multi_cnt", int'(hit_cnt), 1);
        step(1);
        chk("t5_multi_one", int'(shot), 0);
        step(2600);
        chk("t5_sat", int'(hit_cnt), 255);

        // Enemy dies while its bullet is in flight
        do_reset();
        reimux = 10'd300; reimuy = 10'd400;
        set_enm(0, 100, 50);
        enm_alive = 4'b0001;
        step(1);
        enm_alive = 4'b0000;
        step(5);
        chk("t5_dead_vld", int'(bullet_vld[0]), 1);
        chk("t5_dead_y", by(0), 100);
        step(60);
        chk("t5_no_respawn", int'(bullet_vld[0]), 0);

        // Two hits ten ticks apart
        do_reset();
        reimux = 10'd100; reimuy = 10'd50;
        set_enm(0, 100, 50);
        enm_alive = 4'b0001;
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            step(1);
            if (shot) pulses++;
        end
`ifdef ENM_BULLET_IFRAME_EN
        chk("t6_pulses", pulses, 1);
`else
        chk("t6_pulses", pulses, 2);
`endif
        step(40);

        // Random play with gated ticks and sporadic resets
        for (int r = 0; r < 40; r++) begin
            for (int e = 0; e < NE; e++) begin
                px = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 440));
                set_enm(e, px, int'($urandom_range(0, 480)));
            end
            enm_alive = NE'($urandom);
            pe = int'($urandom_range(0, NE - 1));
            px = int'($urandom_range(0, 40));
            px = px - 20 + int'(enm_x[pe*W +: W]);
            py = int'($urandom_range(0, 200));
            py = py - 20 + int'(enm_y[pe*W +: W]);
            if (px < 0) px = 0;
            if (px > 1023) px = 1023;
            if (py < 0) py = 0;
            if (py > 1023) py = 1023;
            reimux = W'(px);
            reimuy = W'(py);
            for (int c = 0; c < 60; c++) begin
                tick  = ($urandom_range(0, 9) < 7);
                rst_n = ($urandom_range(0, 299) != 0);
                step(1);
            end
            rst_n = 1'b1;
        end
        tick = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
